// File: rtl/cnn_accel_pkg.sv
// Shared constants for the CNN accelerator datapath blocks: FSM state
// encodings, channel codes and default widths shared by the adder and writer.
package cnn_accel_pkg;

    localparam int DEF_MEM_OUT_DATA_WIDTH   = 16;
    localparam int DEF_BITWIDTH_DATA_IN     = 32;
    localparam int DEF_BITWIDTH_MAX_IF_SIZE = 22;
    localparam int DEF_BITWIDTH_IF_CHANNELS = 3;

    localparam logic [1:0] STATE_IDLE    = 2'd0;
    localparam logic [1:0] STATE_WRITE   = 2'd1;
    localparam logic [1:0] STATE_DONE    = 2'd2;
    localparam logic [1:0] STATE_WAIT_OK = 2'd3;

    localparam logic [2:0] CH1 = 3'd1;
    localparam logic [2:0] CH2 = 3'd2;
    localparam logic [2:0] CH3 = 3'd3;

endpackage

// File: rtl/writer_addr_counter.sv
// Write-address counter for channel_mem_writer: synchronous clear, count
// enable and a terminal flag raised while the count equals the limit.
module writer_addr_counter
    import cnn_accel_pkg::*;
#(
    parameter int WIDTH = DEF_BITWIDTH_MAX_IF_SIZE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             terminal
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign terminal = (count == limit);

endmodule

// File: rtl/channel_mem_writer.sv
// Writes one channel's serial convolution results into Mem1..Mem3 in raster
// order. Define CHANNEL_WRITER_SATURATE_EN to saturate instead of truncate.
module channel_mem_writer
    import cnn_accel_pkg::*;
#(
    parameter int MEM_OUT_DATA_WIDTH   = DEF_MEM_OUT_DATA_WIDTH,
    parameter int BITWIDTH_DATA_IN     = DEF_BITWIDTH_DATA_IN,
    parameter int BITWIDTH_MAX_IF_SIZE = DEF_BITWIDTH_MAX_IF_SIZE,
    parameter int BITWIDTH_IF_CHANNELS = DEF_BITWIDTH_IF_CHANNELS
) (
    input  logic                            CHANNEL_WRITER_Clk,
    input  logic                            CHANNEL_WRITER_Reset_n,
    input  logic                            CHANNEL_WRITER_Start_Routine,
    input  logic [BITWIDTH_IF_CHANNELS-1:0] CHANNEL_WRITER_Channel_Sel,
    input  logic [BITWIDTH_MAX_IF_SIZE-1:0] CHANNEL_WRITER_Of_Size,
    input  logic [BITWIDTH_DATA_IN-1:0]     CHANNEL_WRITER_Data_In,
    input  logic                            CHANNEL_WRITER_Data_Valid,
    input  logic                            CHANNEL_WRITER_Routine_Finished_Already_Ok,
    output logic [MEM_OUT_DATA_WIDTH-1:0]   CHANNEL_WRITER_Mem_Wr_Data,
    output logic [BITWIDTH_MAX_IF_SIZE-1:0] CHANNEL_WRITER_Mem_Wr_Addr,
    output logic                            CHANNEL_WRITER_Mem1_We,
    output logic                            CHANNEL_WRITER_Mem2_We,
    output logic                            CHANNEL_WRITER_Mem3_We,
    output logic                            CHANNEL_WRITER_Busy,
    output logic                            CHANNEL_WRITER_Routine_Finished_Already
);

    logic [1:0]                      state;
    logic [BITWIDTH_IF_CHANNELS-1:0] sel_q;
    logic [BITWIDTH_MAX_IF_SIZE-1:0] size_q;
    logic [BITWIDTH_MAX_IF_SIZE-1:0] count;
    logic                            terminal;
    logic                            accept;
    logic                            sel_ch1;
    logic                            sel_ch2;
    logic                            sel_ch3;
    logic                            start_now;
    logic [MEM_OUT_DATA_WIDTH-1:0]   conv_data;

    assign start_now = (state == STATE_IDLE) && CHANNEL_WRITER_Start_Routine;
    assign accept    = (state == STATE_WRITE) && CHANNEL_WRITER_Data_Valid;
    assign sel_ch1   = (sel_q == BITWIDTH_IF_CHANNELS'(CH1));
    assign sel_ch2   = (sel_q == BITWIDTH_IF_CHANNELS'(CH2));
    assign sel_ch3   = (sel_q == BITWIDTH_IF_CHANNELS'(CH3));

    // The counter is held at the limit after the last sample so it can never wrap.
    writer_addr_counter #(
        .WIDTH(BITWIDTH_MAX_IF_SIZE)
    ) u_addr_counter (
        .clk      (CHANNEL_WRITER_Clk),
        .rst_n    (CHANNEL_WRITER_Reset_n),
        .clear    (start_now),
        .enable   (accept && !terminal),
        .limit    (size_q),
        .count    (count),
        .terminal (terminal)
    );

`ifdef CHANNEL_WRITER_SATURATE_EN
    localparam logic signed [BITWIDTH_DATA_IN-1:0] SAT_MAX =
        {{(BITWIDTH_DATA_IN-MEM_OUT_DATA_WIDTH+1){1'b0}}, {(MEM_OUT_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [BITWIDTH_DATA_IN-1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        conv_data = CHANNEL_WRITER_Data_In[MEM_OUT_DATA_WIDTH-1:0];
        if ($signed(CHANNEL_WRITER_Data_In) > SAT_MAX) begin
            conv_data = SAT_MAX[MEM_OUT_DATA_WIDTH-1:0];
        end else if ($signed(CHANNEL_WRITER_Data_In) < SAT_MIN) begin
            conv_data = SAT_MIN[MEM_OUT_DATA_WIDTH-1:0];
        end
    end
`else
    logic unused_data_upper;

    assign conv_data         = CHANNEL_WRITER_Data_In[MEM_OUT_DATA_WIDTH-1:0];
    assign unused_data_upper = ^CHANNEL_WRITER_Data_In[BITWIDTH_DATA_IN-1:MEM_OUT_DATA_WIDTH];
`endif

    // Write port outputs default to zero every cycle so they read 0 without a WE.
    always_ff @(posedge CHANNEL_WRITER_Clk or negedge CHANNEL_WRITER_Reset_n) begin
        if (!CHANNEL_WRITER_Reset_n) begin
            state                                   <= STATE_IDLE;
            sel_q                                   <= '0;
            size_q                                  <= '0;
            CHANNEL_WRITER_Mem_Wr_Data              <= '0;
            CHANNEL_WRITER_Mem_Wr_Addr              <= '0;
            CHANNEL_WRITER_Mem1_We                  <= 1'b0;
            CHANNEL_WRITER_Mem2_We                  <= 1'b0;
            CHANNEL_WRITER_Mem3_We                  <= 1'b0;
            CHANNEL_WRITER_Routine_Finished_Already <= 1'b0;
        end else begin
            CHANNEL_WRITER_Mem_Wr_Data <= '0;
            CHANNEL_WRITER_Mem_Wr_Addr <= '0;
            CHANNEL_WRITER_Mem1_We     <= 1'b0;
            CHANNEL_WRITER_Mem2_We     <= 1'b0;
            CHANNEL_WRITER_Mem3_We     <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (CHANNEL_WRITER_Start_Routine) begin
                        sel_q  <= CHANNEL_WRITER_Channel_Sel;
                        size_q <= CHANNEL_WRITER_Of_Size;
                        state  <= STATE_WRITE;
                    end
                end
                STATE_WRITE: begin
                    if (accept) begin
                        if (sel_ch1 || sel_ch2 || sel_ch3) begin
                            CHANNEL_WRITER_Mem_Wr_Data <= conv_data;
                            CHANNEL_WRITER_Mem_Wr_Addr <= count;
                        end
                        CHANNEL_WRITER_Mem1_We <= sel_ch1;
                        CHANNEL_WRITER_Mem2_We <= sel_ch2;
                        CHANNEL_WRITER_Mem3_We <= sel_ch3;
                        if (terminal) begin
                            state <= STATE_DONE;
                        end
                    end
                end
                STATE_DONE: begin
                    CHANNEL_WRITER_Routine_Finished_Already <= 1'b1;
                    state                                   <= STATE_WAIT_OK;
                end
                STATE_WAIT_OK: begin
                    if (CHANNEL_WRITER_Routine_Finished_Already_Ok) begin
                        CHANNEL_WRITER_Routine_Finished_Already <= 1'b0;
                        state                                   <= STATE_IDLE;
                    end
                end
                default: begin
                    state <= STATE_IDLE;
                end
            endcase
        end
    end

    assign CHANNEL_WRITER_Busy = (state == STATE_WRITE) || (state == STATE_DONE);

endmodule

// File: doc/channel_mem_writer.md
Name: channel_mem_writer

Overview:
- Write-side partner of the channel-summing adder.
- Takes the serial stream of convolution results for one input channel and writes it, in raster order, into one of three per-channel output memories (Mem1..Mem3), addresses 0..Of_Size.
- Reports completion with the same Routine_Finished_Already / Routine_Finished_Already_Ok handshake the accelerator control FSM uses for the adder.

Parameters:
- MEM_OUT_DATA_WIDTH, 16, width of a channel-memory word (signed).
- BITWIDTH_DATA_IN, 32, width of the incoming signed convolution result.
- BITWIDTH_MAX_IF_SIZE, 22, width of address counter and Of_Size.
- BITWIDTH_IF_CHANNELS, 3, width of channel select.

Ports:
- CHANNEL_WRITER_Clk  in  1  clock, rising edge.
- CHANNEL_WRITER_Reset_n  in  1  asynchronous active-low reset.
- CHANNEL_WRITER_Start_Routine  in  1  start pulse; sampled only in IDLE.
- CHANNEL_WRITER_Channel_Sel  in  BITWIDTH_IF_CHANNELS  target memory 1..3; latched at start.
- CHANNEL_WRITER_Of_Size  in  BITWIDTH_MAX_IF_SIZE  output-feature size minus 1; latched at start.
- CHANNEL_WRITER_Data_In  in  BITWIDTH_DATA_IN  signed result.
- CHANNEL_WRITER_Data_Valid  in  1  Data_In is valid this cycle.
- CHANNEL_WRITER_Routine_Finished_Already_Ok  in  1  controller acknowledge.
- CHANNEL_WRITER_Mem_Wr_Data  out  MEM_OUT_DATA_WIDTH  write data, shared by all three memories.
- CHANNEL_WRITER_Mem_Wr_Addr  out  BITWIDTH_MAX_IF_SIZE  write address, shared.
- CHANNEL_WRITER_Mem1_We / Mem2_We / Mem3_We  out  1 each  one-hot write enables.
- CHANNEL_WRITER_Busy  out  1  high in WRITE and DONE.
- CHANNEL_WRITER_Routine_Finished_Already  out  1  completion flag.

Behaviour:
- Reset (asynchronous, Reset_n = 0), effective at any time including mid-routine:
  - state returns to IDLE;
  - every output and every internal register is forced to 0;
  - the partially written region is left undefined and is not rolled back.
- FSM states:
  - IDLE: Start = 1 latches Channel_Sel and Of_Size, clears the address counter, and moves to WRITE. Data_Valid is ignored in IDLE.
  - WRITE: each cycle with Data_Valid = 1 accepts one sample. On the next cycle the write is presented: Mem_Wr_Data = converted sample, Mem_Wr_Addr = current count, and the selected WE is a single-cycle pulse. The counter then increments. The sample accepted while count == Of_Size is the last one, and the FSM moves to DONE.
  - DONE: lasts exactly one cycle and lets the final write retire; Finished is then set to 1. Next state is WAIT_OK.
  - WAIT_OK: Finished is held at 1 until Ok = 1 is sampled. Finished clears the following cycle and the FSM returns to IDLE.
- Latency and throughput:
  - Registered outputs give 1 cycle from accepted sample to WE.
  - Full throughput: one sample per cycle, back-to-back.
  - Finished rises exactly 2 cycles after the last accepted sample (1 cycle after the last WE).
- Gaps: Data_Valid may drop for any number of cycles in WRITE. No WE is issued and the counter holds.
- Start outside IDLE is ignored. Ok outside WAIT_OK is ignored. If Start and Ok arrive in the same cycle in WAIT_OK, Ok is honoured and Start is dropped.
- Channel_Sel of 0 or above 3: the routine runs and counts normally and Finished is issued, but no WE is ever asserted.
- Of_Size = 0: exactly one write, at address 0.
- The counter never wraps; reaching Of_Size ends the routine.
- Width conversion (default build): Mem_Wr_Data = Data_In[MEM_OUT_DATA_WIDTH-1:0], two's-complement truncation.
- Mem_Wr_Data and Mem_Wr_Addr read 0 whenever no WE is active.

Optional Feature:
- Macro: CHANNEL_WRITER_SATURATE_EN.
- Defined: Data_In is saturated to the signed MEM_OUT_DATA_WIDTH range, i.e. clamped to 32767 / -32768 at the defaults.
- Undefined: plain truncation as above.
- Latency is identical in both builds.

Decomposition:
- Shared package cnn_accel_pkg holds:
  - FSM state encodings: IDLE = 0, WRITE = 1, DONE = 2, WAIT_OK = 3;
  - channel code constants: CH1 = 1, CH2 = 2, CH3 = 3;
  - default width constants shared with the adder.
- One sub-module, writer_addr_counter: BITWIDTH_MAX_IF_SIZE wide, with clear, enable and terminal-count flag (count == limit). It runs on the same clock and asynchronous reset.

Test Plan:
- Reset mid-routine: start with Of_Size = 9, drive 4 samples, then assert Reset_n = 0 → all outputs 0 immediately. A new start then writes again beginning at address 0.
- Basic write: Start, Channel_Sel = 2, Of_Size = 3, Data 10,20,30,40 on consecutive cycles → Mem2_We pulses at addresses 0..3 with data 10..40. Mem1_We and Mem3_We stay 0. Finished rises 2 cycles after the 4th sample.
- Gapped stream and handshake: Channel_Sel = 1, Of_Size = 2, valid pattern 1,0,0,1,1 → exactly 3 writes, at addresses 0,1,2. Finished stays high for 5 cycles until Ok = 1, then drops the next cycle and the FSM is back in IDLE.
- Boundaries:
  - Of_Size = 0 → a single write at address 0.
  - Channel_Sel = 0 → no WE asserted, but Finished is still issued.
  - Start pulsed during WRITE → no effect.
- Width conversion: Data_In = 32'h0001_8000 and -70000 →
  - default build: 16'h8000 and 16'hEE90;
  - with CHANNEL_WRITER_SATURATE_EN: 16'h7FFF and 16'h8000.
